// File: rtl/scr1_tapc_tck_sampler_if.sv
// Sampler I/O bundle: raw TCK/channel inputs, enable/clear controls, filtered strobes and status.
// Latency: none, wiring only.
// Backpressure: none; every signal is a level or a single-cycle strobe.
interface scr1_tapc_tck_sampler_if #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 8
);
    logic                tck_i;
    logic [CH_NUM-1:0]   ch_i;
    logic                en_i;
    logic                err_clr_i;
    logic                tck_rise_o;
    logic                tck_fall_o;
    logic [CH_NUM-1:0]   ch_rise_o;
    logic [CH_NUM-1:0]   ch_fall_o;
    logic                tck_lvl_o;
    logic [CNT_W-1:0]    rise_cnt_o;
    logic                ovr_err_o;

    modport master (
        output tck_i, ch_i, en_i, err_clr_i,
        input  tck_rise_o, tck_fall_o, ch_rise_o, ch_fall_o, tck_lvl_o, rise_cnt_o, ovr_err_o
    );

    modport slave (
        input  tck_i, ch_i, en_i, err_clr_i,
        output tck_rise_o, tck_fall_o, ch_rise_o, ch_fall_o, tck_lvl_o, rise_cnt_o, ovr_err_o
    );
endinterface

// File: rtl/scr1_tapc_tck_sampler.sv
// Oversampling TCK synchroniser with glitch filter, edge strobes, channel capture and overspeed flag.
// Latency: a stable tck_i change strobes SYNC_STAGES+FILT_LEN-1 clk edges after it is first sampled.
// Backpressure: none; the block free-runs and strobes are single-cycle pulses.
module scr1_tapc_tck_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int CH_NUM      = 4,
    parameter int FILT_LEN    = 2,
    parameter int MIN_HALF    = 3,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    pwrup_rst_n,
    scr1_tapc_tck_sampler_if.slave  bus
);
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int HP_W = $clog2(MIN_HALF + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_LEN - 1);
    localparam logic [HP_W-1:0] HP_MAX = HP_W'(MIN_HALF);

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [CH_NUM-1:0]      ch_sync [SYNC_STAGES];
    logic                   tck_s;
    logic [CH_NUM-1:0]      ch_s;

    logic                   tck_f;
    logic [FC_W-1:0]        filt_cnt;
    logic [HP_W-1:0]        hp_cnt;
    logic                   rise_q;
    logic                   fall_q;
    logic [CH_NUM-1:0]      ch_rise_q;
    logic [CH_NUM-1:0]      ch_fall_q;
    logic [CNT_W-1:0]       rise_cnt_q;
    logic                   err_q;

    logic                   mismatch;
    logic                   filt_done;
    logic                   accept;
    logic                   hp_short;

    // Synchronisers run even while disabled so enabling starts from a settled level.
    always_ff @(posedge clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            tck_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ch_sync[i] <= '0;
            end
        end else begin
            tck_sync   <= {tck_sync[SYNC_STAGES-2:0], bus.tck_i};
            ch_sync[0] <= bus.ch_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ch_sync[i] <= ch_sync[i-1];
            end
        end
    end

    assign tck_s     = tck_sync[SYNC_STAGES-1];
    assign ch_s      = ch_sync[SYNC_STAGES-1];
    assign mismatch  = tck_s ^ tck_f;
    assign filt_done = (filt_cnt == FC_MAX);
    assign accept    = bus.en_i & mismatch & filt_done;
    assign hp_short  = (hp_cnt < HP_MAX);

    always_ff @(posedge clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            tck_f    <= 1'b0;
            filt_cnt <= '0;
            hp_cnt   <= HP_MAX;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else if (!bus.en_i) begin
            // Track the line silently so re-enabling never invents an edge.
            tck_f    <= tck_s;
            filt_cnt <= '0;
            hp_cnt   <= HP_MAX;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= accept & tck_s;
            fall_q <= accept & ~tck_s;
            if (!mismatch) begin
                filt_cnt <= '0;
            end else if (!filt_done) begin
                filt_cnt <= filt_cnt + FC_W'(1);
            end else begin
                tck_f    <= tck_s;
                filt_cnt <= '0;
            end
            if (accept) begin
                hp_cnt <= HP_W'(1);
            end else if (hp_short) begin
                hp_cnt <= hp_cnt + HP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            ch_rise_q  <= '0;
            ch_fall_q  <= '0;
            rise_cnt_q <= '0;
        end else begin
            if (accept && tck_s) begin
                ch_rise_q  <= ch_s;
                rise_cnt_q <= rise_cnt_q + CNT_W'(1);
            end
            if (accept && !tck_s) begin
                ch_fall_q <= ch_s;
            end
        end
    end

    // A fresh violation outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge pwrup_rst_n) begin
        if (!pwrup_rst_n) begin
            err_q <= 1'b0;
        end else if (bus.en_i) begin
            if (accept && hp_short) begin
                err_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.tck_rise_o = rise_q;
    assign bus.tck_fall_o = fall_q;
    assign bus.ch_rise_o  = ch_rise_q;
    assign bus.ch_fall_o  = ch_fall_q;
    assign bus.tck_lvl_o  = tck_f;
    assign bus.rise_cnt_o = rise_cnt_q;
    assign bus.ovr_err_o  = err_q;
endmodule

// File: tb/tb_scr1_tapc_tck_sampler.sv
// Bench for scr1_tapc_tck_sampler: two instances (8-bit and 2-bit rise counters) share one stimulus,
// checked each cycle against an edge-level model plus hand-computed expectations.
module tb_scr1_tapc_tck_sampler;
    localparam int SYNC = 2;
    localparam int FILT = 2;
    localparam int MINH = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tck;
    logic [3:0] ch;
    logic       en;
    logic       clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scr1_tapc_tck_sampler_if #(.CH_NUM(4), .CNT_W(8)) bus_a ();
    scr1_tapc_tck_sampler_if #(.CH_NUM(4), .CNT_W(2)) bus_b ();

    assign bus_a.tck_i = tck;  assign bus_b.tck_i = tck;
    assign bus_a.ch_i = ch;    assign bus_b.ch_i = ch;
    assign bus_a.en_i = en;    assign bus_b.en_i = en;
    assign bus_a.err_clr_i = clr;  assign bus_b.err_clr_i = clr;

    scr1_tapc_tck_sampler #(.SYNC_STAGES(SYNC), .CH_NUM(4), .FILT_LEN(FILT), .MIN_HALF(MINH), .CNT_W(8))
        dut_a (.clk(clk), .pwrup_rst_n(rst_n), .bus(bus_a));
    scr1_tapc_tck_sampler #(.SYNC_STAGES(SYNC), .CH_NUM(4), .FILT_LEN(FILT), .MIN_HALF(MINH), .CNT_W(2))
        dut_b (.clk(clk), .pwrup_rst_n(rst_n), .bus(bus_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tck_i/ch_i delayed by SYNC samples; an edge is accepted once the delayed
    // level has disagreed with the filtered level for FILT consecutive enabled cycles.
    int         cyc;
    bit         lvl;
    int         run;
    bit         have_last;
    int         last_acc;
    bit         m_rise, m_fall, m_err, set_now, ms;
    logic [3:0] m_chr, m_chf, mcs;
    int         m_cnt;
    bit         tq[$];
    logic [3:0] cq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl = 0; run = 0; have_last = 0; last_acc = 0; cyc = 0;
            m_rise = 0; m_fall = 0; m_err = 0; m_chr = 0; m_chf = 0; m_cnt = 0;
            tq = {}; cq = {};
            for (int i = 0; i < SYNC; i++) begin
                tq.push_back(1'b0);
                cq.push_back(4'h0);
            end
        end else begin
            ms = tq[0]; mcs = cq[0]; cyc++;
            m_rise = 0; m_fall = 0; set_now = 0;
            if (!en) begin
                lvl = ms; run = 0; have_last = 0;
            end else if (ms == lvl) begin
                run = 0;
            end else begin
                run++;
                if (run == FILT) begin
                    lvl = ms; run = 0;
                    if (ms) begin m_rise = 1; m_cnt++; m_chr = mcs; end
                    else begin m_fall = 1; m_chf = mcs; end
                    if (have_last && (cyc - last_acc) < MINH) begin m_err = 1; set_now = 1; end
                    have_last = 1; last_acc = cyc;
                end
            end
            if (en && !set_now && clr) m_err = 0;
            void'(tq.pop_front()); tq.push_back(tck);
            void'(cq.pop_front()); cq.push_back(ch);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("rise_a", bus_a.tck_rise_o, m_rise);
            chk("fall_a", bus_a.tck_fall_o, m_fall);
            chk("chr_a",  bus_a.ch_rise_o,  m_chr);
            chk("chf_a",  bus_a.ch_fall_o,  m_chf);
            chk("lvl_a",  bus_a.tck_lvl_o,  lvl);
            chk("cnt_a",  bus_a.rise_cnt_o, m_cnt % 256);
            chk("err_a",  bus_a.ovr_err_o,  m_err);
            chk("rise_b", bus_b.tck_rise_o, m_rise);
            chk("cnt_b",  bus_b.rise_cnt_o, m_cnt % 4);
            chk("err_b",  bus_b.ovr_err_o,  m_err);
        end
    end

    int seq[5] = '{1, 2, 3, 0, 1};
    int nf;

    initial begin
        rst_n = 1'b0; tck = 1'b0; ch = 4'hA; en = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rise", bus_a.tck_rise_o, 0);
        chk("rst_lvl",  bus_a.tck_lvl_o, 0);
        chk("rst_cnt",  bus_a.rise_cnt_o, 0);
        chk("rst_err",  bus_a.ovr_err_o, 0);
        chk("rst_chr",  bus_a.ch_rise_o, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Ten rises at a half-period of 8 cycles, strobe expected 4 edges later.
        for (int i = 0; i < 10; i++) begin
            tck = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1;
                chk("rise_lat", bus_a.tck_rise_o, (c == 4));
                if (c == 4 && i < 5) chk("cnt2_seq", bus_b.rise_cnt_o, seq[i]);
            end
            @(negedge clk);
            tck = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("t1_cnt",  bus_a.rise_cnt_o, 10);
        chk("t1_cnt2", bus_b.rise_cnt_o, 2);
        chk("t1_chr",  bus_a.ch_rise_o, 4'hA);
        chk("t1_chf",  bus_a.ch_fall_o, 4'hA);
        chk("t1_err",  bus_a.ovr_err_o, 0);

        // Single-cycle glitch must be swallowed.
        tck = 1'b1;
        @(negedge clk);
        tck = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("gl_rise", bus_a.tck_rise_o, 0);
            chk("gl_lvl",  bus_a.tck_lvl_o, 0);
        end
        chk("gl_cnt", bus_a.rise_cnt_o, 10);
        @(negedge clk);

        // Overspeed: half-period of 2 cycles, error at the second accepted edge.
        ch = 4'h5;
        repeat (6) @(negedge clk);
        tck = 1'b1;
        repeat (2) @(negedge clk);
        tck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ov_rise", bus_a.tck_rise_o, 1);
        chk("ov_err0", bus_a.ovr_err_o, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("ov_fall", bus_a.tck_fall_o, 1);
        chk("ov_err1", bus_a.ovr_err_o, 1);
        chk("ov_chf",  bus_a.ch_fall_o, 4'h5);
        repeat (8) @(negedge clk);
        chk("ov_sticky", bus_a.ovr_err_o, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ov_clr", bus_a.ovr_err_o, 0);

        // Clear coinciding with a new violation: set wins.
        ch = 4'h3;
        repeat (6) @(negedge clk);
        tck = 1'b1;
        repeat (2) @(negedge clk);
        tck = 1'b0;
        repeat (2) @(negedge clk);
        chk("sw_err0", bus_a.ovr_err_o, 0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("sw_fall", bus_a.tck_fall_o, 1);
        chk("sw_err1", bus_a.ovr_err_o, 1);
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("sw_clr", bus_a.ovr_err_o, 0);

        // Enable while TCK is already high: level follows, no rise strobe.
        ch = 4'hC;
        en = 1'b0;
        @(negedge clk);
        tck = 1'b1;
        repeat (6) @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("en_rise", bus_a.tck_rise_o, 0);
        end
        chk("en_lvl", bus_a.tck_lvl_o, 1);
        @(negedge clk);
        tck = 1'b0;
        nf = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            nf += int'(bus_a.tck_fall_o);
        end
        chk("en_falls", nf, 1);
        chk("en_chf", bus_a.ch_fall_o, 4'hC);
        @(negedge clk);

        // Reset two cycles into a rise that follows a recent fall.
        ch = 4'h6;
        tck = 1'b1;
        repeat (8) @(negedge clk);
        tck = 1'b0;
        repeat (2) @(negedge clk);
        tck = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_rise", bus_a.tck_rise_o, 0);
        chk("mr_cnt",  bus_a.rise_cnt_o, 0);
        chk("mr_lvl",  bus_a.tck_lvl_o, 0);
        chk("mr_chr",  bus_a.ch_rise_o, 0);
        chk("mr_chf",  bus_a.ch_fall_o, 0);
        @(negedge clk);
        tck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("mr_quiet", bus_a.tck_rise_o, 0);
        end
        @(negedge clk);
        tck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mr_rise1", bus_a.tck_rise_o, 1);
        chk("mr_err",   bus_a.ovr_err_o, 0);
        chk("mr_cnt1",  bus_a.rise_cnt_o, 1);
        chk("mr_chr1",  bus_a.ch_rise_o, 4'h6);
        @(negedge clk);

        // A few more edges with varying channel data.
        for (int i = 0; i < 3; i++) begin
            ch = 4'(4'h9 + i);
            repeat (4) @(negedge clk);
            tck = 1'b0;
            repeat (8) @(negedge clk);
            tck = 1'b1;
            repeat (8) @(negedge clk);
        end
        chk("end_cnt", bus_a.rise_cnt_o, 4);
        chk("end_chr", bus_a.ch_rise_o, 4'hB);
        chk("end_err", bus_a.ovr_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scr1_tapc_tck_sampler.md
# scr1_tapc_tck_sampler

- Parametrised single-clock oversampling synchroniser for the TAP controller path.
- Samples a raw, asynchronous TCK and CH_NUM TCK-domain level signals in the SysCLK domain, then applies a glitch filter to TCK.
- Produces single-cycle rise/fall strobes plus channel data captured at each filtered edge, a rising-edge counter and a sticky TCK-too-fast error.
- Generalises the divided-TCK load/reset scheme to configurable sync depth, channel count and filter length, and adds enable gating and overspeed detection.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for tck_i and ch_i; legal range ≥2.
- CH_NUM, 4: number of TCK-domain level channels; legal range ≥1.
- FILT_LEN, 2: consecutive clk cycles a new TCK level must persist before it is accepted; legal range ≥1.
- MIN_HALF, 3: minimum legal filtered TCK half-period in clk cycles; legal range ≥1.
- CNT_W, 8: width of the rising-edge counter.

Ports:
- clk  in  1  System clock (SysCLK); the only clock in the block.
- pwrup_rst_n  in  1  Asynchronous active-low reset.
- tck_i  in  1  Raw JTAG TCK, asynchronous to clk; sampled as data, never used as a clock.
- ch_i  in  CH_NUM  TCK-domain level signals, asynchronous to clk.
- en_i  in  1  Sampler enable.
- err_clr_i  in  1  Clears ovr_err_o.
- tck_rise_o  out  1  One-cycle strobe on a filtered TCK rising edge.
- tck_fall_o  out  1  One-cycle strobe on a filtered TCK falling edge.
- ch_rise_o  out  CH_NUM  Channel values captured at the last filtered rise.
- ch_fall_o  out  CH_NUM  Channel values captured at the last filtered fall.
- tck_lvl_o  out  1  Filtered TCK level.
- rise_cnt_o  out  CNT_W  Count of filtered rising edges; wraps.
- ovr_err_o  out  1  Sticky error: TCK half-period was shorter than MIN_HALF.

## Operation
- Synchronisers
  - tck_i and each ch_i bit pass through SYNC_STAGES flops.
  - Last-stage outputs are tck_s and ch_s.
  - The synchronisers run regardless of en_i.
- Filter state
  - tck_f holds the filtered level and drives tck_lvl_o.
  - filt_cnt, 0..FILT_LEN-1, counts consecutive cycles with tck_s != tck_f.
  - hp_cnt counts cycles since the last accepted edge and saturates at MIN_HALF.
- Per clk edge with en_i=1:
  - tck_s == tck_f: filt_cnt←0.
  - tck_s != tck_f and filt_cnt < FILT_LEN-1: filt_cnt←filt_cnt+1.
  - tck_s != tck_f and filt_cnt == FILT_LEN-1: this is an accepted edge.
    - tck_f←tck_s and filt_cnt←0.
    - If the new level is 1: tck_rise_o←1, ch_rise_o←ch_s, rise_cnt_o←rise_cnt_o+1 (modulo 2^CNT_W).
    - If the new level is 0: tck_fall_o←1, ch_fall_o←ch_s.
    - If hp_cnt < MIN_HALF, ovr_err_o←1.
    - hp_cnt←1.
  - Cycles with no accepted edge: hp_cnt←min(hp_cnt+1, MIN_HALF).
- Strobes are 1 only in the cycle after an accepted edge and 0 otherwise. Rise and fall can never both be 1.
- en_i=0, per clk edge:
  - tck_f←tck_s, filt_cnt←0, hp_cnt←MIN_HALF.
  - tck_rise_o←0 and tck_fall_o←0.
  - ch_rise_o, ch_fall_o, rise_cnt_o and ovr_err_o hold.
  - Consequence: asserting en_i while TCK is high produces no spurious rise.
- ovr_err_o
  - Sets on the overspeed condition above.
  - Clears when err_clr_i=1.
  - If set and clear fall in the same cycle, set wins.
- Glitch handling: a tck_s pulse shorter than FILT_LEN cycles resets filt_cnt and produces no strobe.

## Timing
- Reset values: all synchroniser flops 0, tck_f 0, filt_cnt 0, hp_cnt MIN_HALF. All outputs 0.
  - The first accepted edge after reset therefore cannot flag an error.
- Latency: tck_i changes before clk edge k and then holds stable. The strobe is visible after edge k+SYNC_STAGES+FILT_LEN-1.
  - With the defaults that is 4 edges.
- ch_i must be stable for at least SYNC_STAGES+FILT_LEN cycles before the TCK edge it belongs to.
- Reset mid-operation: everything returns to reset values at once. No strobe is emitted for the edge in flight.
- Worst-case throughput with no error: one accepted edge per MIN_HALF cycles. This requires the tck_i half-period ≥ MIN_HALF clk cycles.

## Test plan
- Defaults, tck_i toggles every 8 clk cycles, ch_i=4'hA, 10 rising edges:
  - tck_rise_o pulses 10 times, each 4 edges after the tck_i rise.
  - ch_rise_o=4'hA, rise_cnt_o=10, ovr_err_o=0.
- 1-cycle high glitch on tck_i while tck_f=0, FILT_LEN=2: no strobe, tck_lvl_o stays 0, rise_cnt_o unchanged.
- tck_i half-period of 2 clk cycles, MIN_HALF=3:
  - ovr_err_o rises at the second accepted edge and stays set.
  - err_clr_i for 1 cycle with no new edge → 0.
  - err_clr_i asserted in the same cycle as a new violation → remains 1.
- en_i=0 while tck_i=1, then en_i=1: no tck_rise_o, tck_lvl_o=1.
  - The next tck_i fall gives exactly one tck_fall_o.
- CNT_W=2, 5 rises: rise_cnt_o sequence 1,2,3,0,1.
- pwrup_rst_n pulsed low 2 cycles after a tck_i rise (edge not yet accepted): no strobe, all outputs 0, hp_cnt reloads so the next edge sets no error.
